// File: rtl/vta_beat_packer.sv
// ============================================================================
// vta_beat_packer: packs IN_W read beats into OUT_W queue words, throttled by
// downstream queue occupancy. Optional stats under VTA_BEAT_PACKER_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vta_beat_packer #(
  parameter int IN_W       = 64,
  parameter int OUT_W      = 128,
  parameter int CNT_W      = 8,
  parameter int FILL_LIMIT = 254
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_flush,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [IN_W-1:0]  io_in_bits,
  input  logic             io_in_last,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [OUT_W-1:0] io_out_bits,
  input  logic [CNT_W-1:0] io_count
`ifdef VTA_BEAT_PACKER_STATS_EN
  ,
  output logic [31:0]      io_stat_words,
  output logic [15:0]      io_stat_partial,
  output logic [31:0]      io_stat_stall
`endif
);

  localparam int c_RATIO  = OUT_W / IN_W;
  localparam int c_LANE_W = $clog2(c_RATIO);
  localparam logic [CNT_W-1:0]    c_FILL_LIMIT = CNT_W'(FILL_LIMIT);
  localparam logic [c_LANE_W-1:0] c_TOP_LANE   = c_LANE_W'(c_RATIO - 1);

  logic [c_LANE_W-1:0] r_lane;
  logic [OUT_W-1:0]    r_asm;
  logic                r_out_valid;
  logic [OUT_W-1:0]    r_out_bits;

  logic                w_throttle;
  logic                w_in_fire;
  logic                w_out_fire;
  logic                w_complete;
  logic [OUT_W-1:0]    w_merged;

  assign w_throttle  = (io_count >= c_FILL_LIMIT);
  // Reset also gates ready so upstream sees back-pressure while reset is held.
  assign io_in_ready = !reset && !io_flush && !w_throttle && (!r_out_valid || io_out_ready);
  assign w_in_fire   = io_in_valid && io_in_ready;
  assign w_out_fire  = r_out_valid && io_out_ready;
  assign w_complete  = w_in_fire && ((r_lane == c_TOP_LANE) || io_in_last);

  // Lanes above r_lane are already zero because r_asm is cleared on every word.
  always_comb begin
    w_merged = r_asm;
    for (int i = 0; i < c_RATIO; i++) begin
      if (r_lane == c_LANE_W'(i)) begin
        w_merged[i*IN_W +: IN_W] = io_in_bits;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lane      <= '0;
      r_asm       <= '0;
      r_out_valid <= 1'b0;
      r_out_bits  <= '0;
    end else if (io_flush) begin
      r_lane      <= '0;
      r_asm       <= '0;
      r_out_valid <= 1'b0;
      r_out_bits  <= '0;
    end else begin
      if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
      if (w_complete) begin
        r_out_bits  <= w_merged;
        r_out_valid <= 1'b1;
        r_lane      <= '0;
        r_asm       <= '0;
      end else if (w_in_fire) begin
        r_lane <= r_lane + 1'b1;
        r_asm  <= w_merged;
      end
    end
  end

  assign io_out_valid = r_out_valid;
  assign io_out_bits  = r_out_bits;

`ifdef VTA_BEAT_PACKER_STATS_EN
  logic [31:0] r_stat_words;
  logic [15:0] r_stat_partial;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stat_words   <= '0;
      r_stat_partial <= '0;
      r_stat_stall   <= '0;
    end else if (io_flush) begin
      r_stat_words   <= '0;
      r_stat_partial <= '0;
      r_stat_stall   <= '0;
    end else begin
      if (w_out_fire && !(&r_stat_words)) begin
        r_stat_words <= r_stat_words + 1'b1;
      end
      if (w_complete && io_in_last && (r_lane != c_TOP_LANE) && !(&r_stat_partial)) begin
        r_stat_partial <= r_stat_partial + 1'b1;
      end
      if (io_in_valid && w_throttle && !(&r_stat_stall)) begin
        r_stat_stall <= r_stat_stall + 1'b1;
      end
    end
  end

  assign io_stat_words   = r_stat_words;
  assign io_stat_partial = r_stat_partial;
  assign io_stat_stall   = r_stat_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vta_beat_packer.sv
// Testbench for vta_beat_packer: directed corner sequences, a combinational
// ready table, and a randomized run against a beat-queue reference model.
`default_nettype none

module tb_vta_beat_packer;

  localparam int IN_W  = 64;
  localparam int OUT_W = 128;
  localparam int RATIO = OUT_W / IN_W;

  logic             clock = 1'b0;
  logic             reset;
  logic             io_flush;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [IN_W-1:0]  io_in_bits;
  logic             io_in_last;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [OUT_W-1:0] io_out_bits;
  logic [7:0]       io_count;
`ifdef VTA_BEAT_PACKER_STATS_EN
  logic [31:0]      io_stat_words;
  logic [15:0]      io_stat_partial;
  logic [31:0]      io_stat_stall;
`endif

  vta_beat_packer dut (
    .clock        (clock),
    .reset        (reset),
    .io_flush     (io_flush),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_bits   (io_in_bits),
    .io_in_last   (io_in_last),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (io_out_bits),
    .io_count     (io_count)
`ifdef VTA_BEAT_PACKER_STATS_EN
    ,
    .io_stat_words   (io_stat_words),
    .io_stat_partial (io_stat_partial),
    .io_stat_stall   (io_stat_stall)
`endif
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    io_flush     = 1'b0;
    io_in_valid  = 1'b0;
    io_in_bits   = '0;
    io_in_last   = 1'b0;
    io_out_ready = 1'b1;
    io_count     = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic beat(input logic [IN_W-1:0] d, input logic last);
    io_in_valid = 1'b1;
    io_in_bits  = d;
    io_in_last  = last;
  endtask

  typedef struct {
    logic [7:0] count;
    logic       flush;
    logic       out_ready;
    logic       exp_ready;
  } vec_t;

  vec_t tbl[7];

  // Reference model state: beats collected for the word in progress plus the
  // word currently presented downstream.
  logic [IN_W-1:0]  m_beats[$];
  logic             m_valid;
  logic [OUT_W-1:0] m_word;

  function automatic logic [OUT_W-1:0] pack(input logic [IN_W-1:0] b[$]);
    logic [OUT_W-1:0] w;
    w = '0;
    foreach (b[i]) w[i*IN_W +: IN_W] = b[i];
    return w;
  endfunction

  localparam logic [IN_W-1:0] A1 = {4{16'h1111}};
  localparam logic [IN_W-1:0] A2 = {4{16'h2222}};
  localparam logic [IN_W-1:0] A3 = {4{16'h3333}};
  localparam logic [IN_W-1:0] A4 = {4{16'h4444}};
  localparam logic [IN_W-1:0] BA = 64'hAAAA_0000_0000_000A;
  localparam logic [IN_W-1:0] BB = 64'hBBBB_0000_0000_000B;
  localparam logic [IN_W-1:0] BC = 64'hCCCC_0000_0000_000C;
  localparam logic [IN_W-1:0] BD = 64'hDDDD_0000_0000_000D;

  initial begin
    reset = 1'b1;
    idle_inputs();
    #1;
    check("reset_out_valid", {127'b0, io_out_valid}, 128'd0);
    check("reset_in_ready",  {127'b0, io_in_ready},  128'd0);
    do_reset();
    check("reset_out_bits", io_out_bits, 128'd0);
`ifdef VTA_BEAT_PACKER_STATS_EN
    check("reset_stat_words", {96'b0, io_stat_words}, 128'd0);
`endif

    // Combinational ready table with no word pending.
    tbl[0] = '{8'd0,   1'b0, 1'b1, 1'b1};
    tbl[1] = '{8'd253, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{8'd254, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'd255, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{8'd0,   1'b1, 1'b1, 1'b0};
    tbl[5] = '{8'd200, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{8'd254, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      io_count     = tbl[i].count;
      io_flush     = tbl[i].flush;
      io_out_ready = tbl[i].out_ready;
      #1;
      check($sformatf("tbl_ready[%0d]", i), {127'b0, io_in_ready}, {127'b0, tbl[i].exp_ready});
    end
    do_reset();

    // 1: four beats, two full words, one cycle after each second beat.
    beat(A1, 1'b0); step();
    check("t1_no_word_yet", {127'b0, io_out_valid}, 128'd0);
    beat(A2, 1'b0); step();
    check("t1_w0_valid", {127'b0, io_out_valid}, 128'd1);
    check("t1_w0_bits", io_out_bits, {A2, A1});
    beat(A3, 1'b0); step();
    check("t1_w0_taken", {127'b0, io_out_valid}, 128'd0);
    beat(A4, 1'b1); step();
    check("t1_w1_valid", {127'b0, io_out_valid}, 128'd1);
    check("t1_w1_bits", io_out_bits, {A4, A3});
    io_in_valid = 1'b0; io_in_last = 1'b0; step();
    check("t1_no_extra", {127'b0, io_out_valid}, 128'd0);

    // 2: odd beat count ends in a zero-padded partial word.
    do_reset();
    beat(BA, 1'b0); step();
    beat(BB, 1'b0); step();
    check("t2_w0_bits", io_out_bits, {BB, BA});
    beat(BC, 1'b1); step();
    check("t2_w1_valid", {127'b0, io_out_valid}, 128'd1);
    check("t2_w1_bits", io_out_bits, {64'd0, BC});
`ifdef VTA_BEAT_PACKER_STATS_EN
    check("t2_stat_partial", {112'b0, io_stat_partial}, 128'd1);
`endif
    io_in_valid = 1'b0; io_in_last = 1'b0; step();

    // 3: back-pressure holds the word and blocks input until released.
    do_reset();
    io_out_ready = 1'b0;
    beat(BA, 1'b0); step();
    beat(BB, 1'b0); step();
    beat(BC, 1'b0);
    #1;
    check("t3_blocked", {127'b0, io_in_ready}, 128'd0);
    step(); step();
    check("t3_held_valid", {127'b0, io_out_valid}, 128'd1);
    check("t3_held_bits", io_out_bits, {BB, BA});
    io_out_ready = 1'b1;
    #1;
    check("t3_release_ready", {127'b0, io_in_ready}, 128'd1);
    step();
    check("t3_taken", {127'b0, io_out_valid}, 128'd0);
    beat(BD, 1'b1); step();
    check("t3_next_word", io_out_bits, {BD, BC});
    io_in_valid = 1'b0; io_in_last = 1'b0; step();

    // 4: occupancy throttle and stall counting.
    do_reset();
    io_count = 8'd254;
    beat(BA, 1'b0);
    #1;
    check("t4_throttled", {127'b0, io_in_ready}, 128'd0);
    step(); step(); step();
`ifdef VTA_BEAT_PACKER_STATS_EN
    check("t4_stat_stall", {96'b0, io_stat_stall}, 128'd3);
`endif
    check("t4_no_word", {127'b0, io_out_valid}, 128'd0);
    io_count = 8'd253;
    #1;
    check("t4_resume", {127'b0, io_in_ready}, 128'd1);
    step();
    beat(BB, 1'b0); step();
    check("t4_word", io_out_bits, {BB, BA});
    io_in_valid = 1'b0; step();

    // 5: flush discards a partial word and blocks a concurrent beat.
    do_reset();
    beat(BA, 1'b0); step();
    io_flush = 1'b1; beat(BB, 1'b0);
    #1;
    check("t5_flush_blocks", {127'b0, io_in_ready}, 128'd0);
    step();
    io_flush = 1'b0; io_in_valid = 1'b0; step();
    check("t5_no_word", {127'b0, io_out_valid}, 128'd0);
    beat(BC, 1'b0); step();
    check("t5_still_none", {127'b0, io_out_valid}, 128'd0);
    beat(BD, 1'b0); step();
    check("t5_clean_word", io_out_bits, {BD, BC});
    io_in_valid = 1'b0; step();

    // 6: asynchronous reset between edges, with a word pending and mid-burst.
    do_reset();
    beat(BA, 1'b0); step();
    beat(BB, 1'b0); step();
    io_in_valid = 1'b0; io_out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("t6_async_valid", {127'b0, io_out_valid}, 128'd0);
    check("t6_async_ready", {127'b0, io_in_ready}, 128'd0);
    step(); reset = 1'b0; io_out_ready = 1'b1; step();
    beat(BC, 1'b0); step();
    io_in_valid = 1'b0;
    #2 reset = 1'b1;
    step(); reset = 1'b0; step();
    beat(BD, 1'b1); step();
    check("t6_fresh_word", io_out_bits, {64'd0, BD});
    io_in_valid = 1'b0; io_in_last = 1'b0; step();

    // Randomized run against the beat-queue model.
    do_reset();
    m_beats.delete();
    m_valid = 1'b0;
    m_word  = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic exp_ready;
      io_in_valid  = ($urandom_range(0, 9) < 7);
      io_in_bits   = {$urandom, $urandom};
      io_in_last   = ($urandom_range(0, 4) == 0);
      io_out_ready = ($urandom_range(0, 9) < 7);
      io_flush     = ($urandom_range(0, 39) == 0);
      io_count     = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(252, 255))
                                                 : 8'($urandom_range(0, 251));
      #1;
      exp_ready = !io_flush && (io_count < 8'd254) && (!m_valid || io_out_ready);
      check("rnd_in_ready", {127'b0, io_in_ready}, {127'b0, exp_ready});
      check("rnd_out_valid", {127'b0, io_out_valid}, {127'b0, m_valid});
      if (m_valid) check("rnd_out_bits", io_out_bits, m_word);
      if (io_flush) begin
        m_beats.delete();
        m_valid = 1'b0;
      end else begin
        if (m_valid && io_out_ready) m_valid = 1'b0;
        if (exp_ready && io_in_valid) begin
          m_beats.push_back(io_in_bits);
          if (m_beats.size() == RATIO || io_in_last) begin
            m_word  = pack(m_beats);
            m_valid = 1'b1;
            m_beats.delete();
          end
        end
      end
      step();
    end
    idle_inputs();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
